parity_checker: RTL and testbench
=================================

Name: parity_checker

Overview:
- Receive-side counterpart of parity_generator: checks a data word plus its parity bit against the configured parity type.
- Registers the word through a one-stage pipeline and flags per-beat errors.
- Keeps a sticky error flag and a saturating error count.
- Enters a FAULT lockout after a run of consecutive errors; the lockout drops traffic until software clears it.

Parameters:
- DATA_WIDTH, 8, width of data_in/data_out.
- PARITY_TYPE, 0, 0 = even parity (parity bit = XOR of data), 1 = odd parity (parity bit = XNOR of data).
- CNT_WIDTH, 16, width of err_count.
- ERR_THRESH, 4, consecutive errored beats that force FAULT. Legal range is 1 to 255.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- clr_in  input  1  synchronous clear of sticky flag, counters and FAULT
- data_in  input  DATA_WIDTH  received data word
- parity_in  input  1  received parity bit
- valid_in  input  1  data_in/parity_in qualify this cycle
- data_out  output  DATA_WIDTH  registered copy of data_in
- valid_out  output  1  data_out valid (never asserted in FAULT)
- parity_err  output  1  registered per-beat error, aligned with data_out
- err_sticky  output  1  set on any error since last clear
- err_count  output  CNT_WIDTH  total errored beats, saturating
- fault  output  1  high while in FAULT state

Behaviour:
- Reset (async, rst=1): all outputs 0, state=OK, consecutive counter=0.
- Error check: expected = (^data_in) ^ PARITY_TYPE; err = valid_in & (parity_in != expected). Combinational check, registered result.
- Latency: 1 cycle. A beat on valid_in at edge N produces data_out/valid_out/parity_err at edge N+1.
- data_out updates only on valid_in=1, otherwise holds. valid_out and parity_err are 0 on cycles without an accepted beat.
- No backpressure: a beat is accepted every cycle valid_in=1.
- State OK:
  - Beat with err: consec += 1, err_sticky <= 1, err_count += 1 (saturating at all-ones, no wrap).
  - Beat without err: consec <= 0.
  - Cycles with valid_in=0: consec unchanged.
  - When the beat raises consec to ERR_THRESH, go to FAULT on that edge. That beat still appears on valid_out/parity_err.
- State FAULT:
  - fault=1, valid_out=0, parity_err=0. Data is dropped; data_out holds its last value.
  - Errored beats still increment err_count (saturating).
  - Stays in FAULT until clr_in or rst.
- clr_in=1 (synchronous): err_sticky, err_count and consec go to 0; state goes to OK; fault goes to 0.
  - clr_in has priority over a simultaneous errored beat: that beat's error is not counted and does not set sticky.
  - In OK, the same beat still passes to data_out/valid_out/parity_err normally.
  - In FAULT, the simultaneous beat is dropped; FAULT exits on the same edge.
- Reset mid-stream: an in-flight beat is discarded; valid_out drops immediately (async).
- ERR_THRESH=1: the first error enters FAULT.

Optional Feature:
- Macro: PARITY_CHECKER_ERR_COUNT_EN.
- Defined: err_count is implemented as above.
- Undefined: the counter logic is removed and err_count is tied to 0. err_sticky, parity_err and the FAULT machine are unchanged.

Test Plan:
- Defaults (8-bit, even); valid_in beats 0xFF/p=0 then 0x54/p=1 -> next cycle data_out 0xFF then 0x54, parity_err 0 both, err_count 0.
- Defaults; 0x54/p=0 -> one cycle later parity_err=1, err_sticky=1, err_count=1. Following 0x00/p=0 -> parity_err=0, consec reset, err_sticky stays 1.
- PARITY_TYPE=1; 0xFF/p=1 -> no error. 0xFF/p=0 -> parity_err=1.
- ERR_THRESH=4; four consecutive errored beats -> fourth beat seen on valid_out with parity_err=1 and fault=1 the same cycle. Later beats give valid_out=0 while err_count keeps rising to 6 after two more errors. Pulse clr_in -> fault=0, err_count=0, the next good beat passes.
- CNT_WIDTH=2, ERR_THRESH=255; six errored beats -> err_count saturates at 3. clr_in together with an errored beat -> err_count=0, err_sticky=0, and that beat is still output with parity_err=1.
- Assert rst asynchronously mid-stream after 2 errors -> all outputs 0 without waiting for a clock edge. Next error after release -> err_count=1, consec=1, no FAULT.

Source files
------------

// File: rtl/parity_checker.sv
// Receive-side parity checker with 1-cycle pipeline, sticky error flag and FAULT lockout.
// Define PARITY_CHECKER_ERR_COUNT_EN to build the saturating err_count; otherwise it reads 0.
module parity_checker #(
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY_TYPE = 0,
    parameter int CNT_WIDTH   = 16,
    parameter int ERR_THRESH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  parity_in,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  parity_err,
    output logic                  err_sticky,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic                  fault
);

    typedef enum logic {
        ST_OK    = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t                r_state;
    logic [7:0]            r_consec;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_perr;
    logic                  r_sticky;
    logic                  r_fault;

    logic w_expected;
    logic w_err;
    logic w_thresh_hit;

    assign w_expected   = (^data_in) ^ PARITY_TYPE[0];
    assign w_err        = valid_in & (parity_in != w_expected);
    // consec is compared before increment so the threshold beat itself trips FAULT
    assign w_thresh_hit = (r_consec == 8'(ERR_THRESH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_OK;
            r_consec <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_perr   <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            if (clr_in) begin
                r_state  <= ST_OK;
                r_consec <= '0;
                r_fault  <= 1'b0;
                if (r_state == ST_OK && valid_in) begin
                    r_data  <= data_in;
                    r_valid <= 1'b1;
                    r_perr  <= w_err;
                end
            end else begin
                case (r_state)
                    ST_OK: begin
                        if (valid_in) begin
                            r_data  <= data_in;
                            r_valid <= 1'b1;
                            r_perr  <= w_err;
                            if (w_err) begin
                                r_consec <= r_consec + 8'd1;
                                if (w_thresh_hit) begin
                                    r_state <= ST_FAULT;
                                    r_fault <= 1'b1;
                                end
                            end else begin
                                r_consec <= '0;
                            end
                        end
                    end
                    ST_FAULT: begin
                        r_fault <= 1'b1;
                    end
                    default: begin
                        r_state <= ST_OK;
                        r_fault <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky <= 1'b0;
        end else if (clr_in) begin
            r_sticky <= 1'b0;
        end else if (w_err) begin
            r_sticky <= 1'b1;
        end
    end

`ifdef PARITY_CHECKER_ERR_COUNT_EN
    logic [CNT_WIDTH-1:0] r_err_count;

    // counts in both OK and FAULT; holds at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (clr_in) begin
            r_err_count <= '0;
        end else if (w_err && (r_err_count != {CNT_WIDTH{1'b1}})) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = '0;
`endif

    assign data_out   = r_data;
    assign valid_out  = r_valid;
    assign parity_err = r_perr;
    assign err_sticky = r_sticky;
    assign fault      = r_fault;

endmodule

// File: tb/tb_parity_checker.sv
// Self-checking bench for parity_checker: four configurations share one stimulus stream
// and are compared every cycle against a behavioural model, plus directed literal checks.
module tb_parity_checker;

`ifdef PARITY_CHECKER_ERR_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam int N = 4;

    function automatic int pt_of(input int k);
        return (k == 1) ? 1 : 0;
    endfunction
    function automatic int cw_of(input int k);
        return (k == 2) ? 2 : 16;
    endfunction
    function automatic int th_of(input int k);
        return (k == 2) ? 255 : ((k == 3) ? 1 : 4);
    endfunction

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] din = 8'h00;
    logic       par = 1'b0;
    logic       valid = 1'b0;

    logic [7:0]  dq[N];
    logic        vq[N];
    logic        pq[N];
    logic        sq[N];
    logic        fq[N];
    logic [15:0] cq[N];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int CW = cw_of(g);
        logic [CW-1:0] cnt_w;
        parity_checker #(
            .DATA_WIDTH (8),
            .PARITY_TYPE(pt_of(g)),
            .CNT_WIDTH  (CW),
            .ERR_THRESH (th_of(g))
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .clr_in    (clr),
            .data_in   (din),
            .parity_in (par),
            .valid_in  (valid),
            .data_out  (dq[g]),
            .valid_out (vq[g]),
            .parity_err(pq[g]),
            .err_sticky(sq[g]),
            .err_count (cnt_w),
            .fault     (fq[g])
        );
        assign cq[g] = 16'(cnt_w);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one record per configuration
    int m_dout[N], m_vo[N], m_perr[N], m_sticky[N], m_cnt[N], m_fault[N], m_consec[N];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                m_dout[k] <= 0; m_vo[k] <= 0; m_perr[k] <= 0; m_sticky[k] <= 0;
                m_cnt[k] <= 0; m_fault[k] <= 0; m_consec[k] <= 0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                int dout, vo, perr, sticky, cnt, flt, consec, maxc, ones;
                bit e;
                dout = m_dout[k]; sticky = m_sticky[k]; cnt = m_cnt[k];
                flt = m_fault[k]; consec = m_consec[k];
                vo = 0; perr = 0;
                maxc = (1 << cw_of(k)) - 1;
                ones = $countones(din);
                e = valid && (int'(par) != ((ones % 2) ^ pt_of(k)));
                if (clr) begin
                    if (flt == 0 && valid) begin
                        dout = din; vo = 1; perr = e;
                    end
                    sticky = 0; cnt = 0; consec = 0; flt = 0;
                end else begin
                    if (e) begin
                        sticky = 1;
                        if (CNT_EN && cnt < maxc) cnt = cnt + 1;
                    end
                    if (flt == 0 && valid) begin
                        dout = din; vo = 1; perr = e;
                        if (e) begin
                            consec = consec + 1;
                            if (consec >= th_of(k)) flt = 1;
                        end else begin
                            consec = 0;
                        end
                    end
                end
                m_dout[k] <= dout; m_vo[k] <= vo; m_perr[k] <= perr; m_sticky[k] <= sticky;
                m_cnt[k] <= cnt; m_fault[k] <= flt; m_consec[k] <= consec;
            end
        end
    end

    always @(posedge clk) begin
        #2;
        for (int k = 0; k < N; k++) begin
            chk($sformatf("g%0d_data_out", k), int'(dq[k]), m_dout[k]);
            chk($sformatf("g%0d_valid_out", k), int'(vq[k]), m_vo[k]);
            chk($sformatf("g%0d_parity_err", k), int'(pq[k]), m_perr[k]);
            chk($sformatf("g%0d_err_sticky", k), int'(sq[k]), m_sticky[k]);
            chk($sformatf("g%0d_err_count", k), int'(cq[k]), m_cnt[k]);
            chk($sformatf("g%0d_fault", k), int'(fq[k]), m_fault[k]);
        end
    end

    task automatic step(input logic [7:0] d, input logic p, input logic v, input logic c);
        @(negedge clk);
        din = d; par = p; valid = v; clr = c;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_data_out", int'(dq[0]), 0);
        chk("rst_valid_out", int'(vq[0]), 0);
        chk("rst_parity_err", int'(pq[0]), 0);
        chk("rst_sticky", int'(sq[0]), 0);
        chk("rst_count", int'(cq[0]), 0);
        chk("rst_fault", int'(fq[0]), 0);
        @(negedge clk) rst = 1'b0;

        step(8'hFF, 1'b0, 1'b1, 1'b0);
        chk("even_ff_dout", int'(dq[0]), 8'hFF);
        chk("even_ff_vo", int'(vq[0]), 1);
        chk("even_ff_perr", int'(pq[0]), 0);
        chk("odd_ff_p0_perr", int'(pq[1]), 1);
        step(8'h54, 1'b1, 1'b1, 1'b0);
        chk("even_54_dout", int'(dq[0]), 8'h54);
        chk("even_54_perr", int'(pq[0]), 0);
        chk("even_54_cnt", int'(cq[0]), 0);
        step(8'h54, 1'b0, 1'b1, 1'b0);
        chk("even_err_perr", int'(pq[0]), 1);
        chk("even_err_sticky", int'(sq[0]), 1);
        chk("even_err_cnt", int'(cq[0]), CNT_EN ? 1 : 0);
        step(8'h00, 1'b0, 1'b1, 1'b0);
        chk("even_00_perr", int'(pq[0]), 0);
        chk("even_00_sticky", int'(sq[0]), 1);
        step(8'hFF, 1'b1, 1'b1, 1'b0);
        chk("odd_ff_p1_perr", int'(pq[1]), 0);
        chk("odd_ff_p1_vo", int'(vq[1]), 1);
        step(8'h00, 1'b0, 1'b0, 1'b1);
        chk("clr_sticky", int'(sq[0]), 0);
        chk("clr_th1_fault", int'(fq[3]), 0);

        for (int i = 0; i < 4; i++) begin
            step(8'h54, 1'b0, 1'b1, 1'b0);
            chk($sformatf("thr_beat%0d_vo", i), int'(vq[0]), 1);
            chk($sformatf("thr_beat%0d_fault", i), int'(fq[0]), (i == 3) ? 1 : 0);
            if (i == 0) chk("th1_first_err_fault", int'(fq[3]), 1);
        end
        chk("thr_last_perr", int'(pq[0]), 1);
        step(8'h00, 1'b0, 1'b0, 1'b0);
        step(8'h54, 1'b0, 1'b1, 1'b0);
        chk("fault_drop_vo", int'(vq[0]), 0);
        chk("fault_drop_perr", int'(pq[0]), 0);
        chk("fault_hold_dout", int'(dq[0]), 8'h54);
        step(8'h54, 1'b0, 1'b1, 1'b0);
        chk("fault_cnt6", int'(cq[0]), CNT_EN ? 6 : 0);
        chk("sat_cnt3", int'(cq[2]), CNT_EN ? 3 : 0);
        step(8'h54, 1'b0, 1'b1, 1'b1);
        chk("clr_fault_exit", int'(fq[0]), 0);
        chk("clr_fault_drop_vo", int'(vq[0]), 0);
        chk("clr_fault_cnt", int'(cq[0]), 0);
        chk("clr_err_beat_vo", int'(vq[2]), 1);
        chk("clr_err_beat_perr", int'(pq[2]), 1);
        chk("clr_err_beat_cnt", int'(cq[2]), 0);
        chk("clr_err_beat_sticky", int'(sq[2]), 0);
        step(8'h54, 1'b1, 1'b1, 1'b0);
        chk("post_clr_good_vo", int'(vq[0]), 1);
        chk("post_clr_good_perr", int'(pq[0]), 0);

        step(8'h54, 1'b0, 1'b1, 1'b0);
        step(8'h54, 1'b0, 1'b1, 1'b0);
        chk("pre_rst_cnt", int'(cq[0]), CNT_EN ? 2 : 0);
        #1 rst = 1'b1; valid = 1'b0;
        #1;
        chk("async_rst_vo", int'(vq[0]), 0);
        chk("async_rst_dout", int'(dq[0]), 0);
        chk("async_rst_sticky", int'(sq[0]), 0);
        chk("async_rst_cnt", int'(cq[0]), 0);
        @(negedge clk) rst = 1'b0;
        step(8'h54, 1'b0, 1'b1, 1'b0);
        chk("post_rst_cnt", int'(cq[0]), CNT_EN ? 1 : 0);
        chk("post_rst_fault", int'(fq[0]), 0);
        step(8'h54, 1'b0, 1'b1, 1'b0);
        step(8'h54, 1'b0, 1'b1, 1'b0);
        chk("post_rst_consec3_fault", int'(fq[0]), 0);

        repeat (3000) begin
            @(negedge clk);
            din   = 8'($urandom);
            par   = 1'($urandom);
            valid = ($urandom_range(0, 3) != 0);
            clr   = ($urandom_range(0, 39) == 0);
            rst   = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        rst = 1'b0; clr = 1'b0; valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
